// File: rtl/beta_mem_pkg.sv
// ---------------------------------------------------------------------------
// beta_mem_pkg
//   Shared types and helpers for the unified-memory port arbiter.
//   - rd_owner_t : which requester owns the SRAM read data returning next cycle
//   - WORD_BYTES : bytes per SRAM word (32-bit words)
//   - byte_to_word() : converts a byte address into a word address
// ---------------------------------------------------------------------------
package beta_mem_pkg;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_IF   = 2'd1,
        RD_DATA = 2'd2
    } rd_owner_t;

    localparam int WORD_BYTES = 4;

    // Drops the byte-offset bits; callers keep the low AW bits they need.
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr);
        return byte_addr >> $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port synchronous SRAM between the instruction-fetch
//   port (read-only) and the data port (load/store). Data has priority; a
//   streak counter forces a fetch grant after MAX_DSTREAK consecutive data
//   grants taken while a fetch was waiting.
//
// Handshake (both ports): a requester raises *_req with its address/data and
//   holds them stable until *_gnt is seen high in the same cycle; the access
//   is then taken at the next clock edge. *_gnt is combinational from the
//   request and registered state. Read data comes back with *_rvalid exactly
//   one cycle after a read grant; stores never produce *_rvalid. Dropping
//   *_req before it is granted is allowed and leaves no trace.
//
// Ports
//   clk          clock, all state on posedge
//   rst          asynchronous, active-low reset
//   i_req/i_addr fetch request and byte address
//   i_gnt        fetch granted this cycle
//   i_rvalid/i_rdata  fetched word, cycle after i_gnt
//   d_req/d_we/d_addr/d_wdata  data request (d_we=1 store, 0 load)
//   d_gnt        data granted this cycle
//   d_rvalid/d_rdata  loaded word, cycle after load grant
//   sram_en/sram_we/sram_addr/sram_wdata  SRAM command
//   sram_rdata   SRAM read data, valid cycle after a read command
//
// Build option
//   MEM_ARB_STATS_EN : adds saturating 32-bit counters stat_i_gnt,
//   stat_d_gnt and stat_i_stall, readable hierarchically. Port list is the
//   same with or without it.
//
// Observability: the read-return owner state is the internal signal rd_owner.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import beta_mem_pkg::*;
#(
    parameter int AW          = 10,
    parameter int MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          sram_en,
    output logic          sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    localparam logic [3:0] MAX_D = 4'(MAX_DSTREAK);

    logic [3:0] dstreak, dstreak_next;
    rd_owner_t  rd_owner, rd_owner_next;

    logic [31:0] i_word, d_word;
    assign i_word = byte_to_word(i_addr);
    assign d_word = byte_to_word(d_addr);

    // Upper word-address bits beyond the SRAM depth are ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_word[31:AW], d_word[31:AW]};

    // Grants and next-state. Grants are forced low while reset is asserted so
    // every output is quiet during reset.
    always_comb begin
        i_gnt         = 1'b0;
        d_gnt         = 1'b0;
        dstreak_next  = dstreak;
        rd_owner_next = RD_NONE;

        if (rst) begin
            if (d_req && !(i_req && dstreak == MAX_D)) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end

        // The streak only measures how long a waiting fetch has been passed over.
        if (!i_req || i_gnt) begin
            dstreak_next = 4'd0;
        end else if (d_gnt && dstreak != 4'hF) begin
            dstreak_next = dstreak + 4'd1;
        end

        if (i_gnt) begin
            rd_owner_next = RD_IF;
        end else if (d_gnt && !d_we) begin
            rd_owner_next = RD_DATA;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dstreak  <= 4'd0;
            rd_owner <= RD_NONE;
        end else begin
            dstreak  <= dstreak_next;
            rd_owner <= rd_owner_next;
        end
    end

    // SRAM command: driven from whichever port holds the grant, zero when idle.
    always_comb begin
        sram_en    = i_gnt | d_gnt;
        sram_we    = d_gnt & d_we;
        sram_addr  = '0;
        sram_wdata = '0;
        if (d_gnt) begin
            sram_addr  = d_word[AW-1:0];
            sram_wdata = d_wdata;
        end else if (i_gnt) begin
            sram_addr  = i_word[AW-1:0];
        end
    end

    // Read return: route SRAM data to the owner of last cycle's read.
    assign i_rvalid = (rd_owner == RD_IF);
    assign d_rvalid = (rd_owner == RD_DATA);
    assign i_rdata  = i_rvalid ? sram_rdata : 32'd0;
    assign d_rdata  = d_rvalid ? sram_rdata : 32'd0;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_i_gnt;
    logic [31:0] stat_d_gnt;
    logic [31:0] stat_i_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_i_gnt   <= 32'd0;
            stat_d_gnt   <= 32'd0;
            stat_i_stall <= 32'd0;
        end else begin
            if (i_gnt && stat_i_gnt != '1) begin
                stat_i_gnt <= stat_i_gnt + 32'd1;
            end
            if (d_gnt && stat_d_gnt != '1) begin
                stat_d_gnt <= stat_d_gnt + 32'd1;
            end
            if (i_req && !i_gnt && stat_i_stall != '1) begin
                stat_i_stall <= stat_i_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          i_req;
  logic [31:0]   i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [31:0]   d_rdata;
  logic          sram_en;
  logic          sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  int checks;
  int errors;

  // grant codes: 2'b01 = data, 2'b10 = fetch, 2'b00 = none
  logic [1:0] exp_q[$];

  mem_port_arbiter #(.AW(AW), .MAX_DSTREAK(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_gnt      (i_gnt),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM model (write-first) ----------------
  logic [31:0] mem [0:(1<<AW)-1];

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 | 32'(i);
    sram_rdata = 32'd0;
  end

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        mem[sram_addr] <= sram_wdata;
        sram_rdata     <= sram_wdata;
      end else begin
        sram_rdata     <= mem[sram_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    i_req   = 1'b0;
    i_addr  = 32'd0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_addr  = 32'd0;
    d_wdata = 32'd0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
  endtask

  // Runs n cycles with fixed request levels; grants are compared against exp_q
  // and read returns against the previous cycle's expected grant.
  task automatic run_grants(input string tag, input int n, input logic ir, input logic dr,
                            inout logic [1:0] prev);
    logic [1:0] e;
    i_req  = ir;
    d_req  = dr;
    d_we   = 1'b0;
    i_addr = 32'h20;   // word 8
    d_addr = 32'h40;   // word 16
    for (int c = 0; c < n; c++) begin
      mid_cycle();
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b00;
      check({tag, " gnt"}, {30'd0, i_gnt, d_gnt}, {30'd0, e});
      check({tag, " i_rvalid"}, {31'd0, i_rvalid}, {31'd0, prev[1]});
      check({tag, " d_rvalid"}, {31'd0, d_rvalid}, {31'd0, prev[0]});
      if (prev == 2'b01) check({tag, " d_rdata"}, d_rdata, 32'hA000_0010);
      if (prev == 2'b10) check({tag, " i_rdata"}, i_rdata, 32'hA000_0008);
      prev = e;
      next_cycle();
    end
  endtask

  logic [1:0] prev;

  // ---------------- stimulus ----------------
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_inputs();

    // Reset state: requests pending but everything must stay low.
    i_req = 1'b1;
    d_req = 1'b1;
    d_addr = 32'h44;
    mid_cycle();
    check("rst i_gnt",    {31'd0, i_gnt},    32'd0);
    check("rst d_gnt",    {31'd0, d_gnt},    32'd0);
    check("rst sram_en",  {31'd0, sram_en},  32'd0);
    check("rst sram_addr", {22'd0, sram_addr}, 32'd0);
    check("rst rvalid",   {30'd0, i_rvalid, d_rvalid}, 32'd0);
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    mid_cycle();
    check("idle sram_en", {31'd0, sram_en}, 32'd0);
    next_cycle();

    // 1: fetch only, address 0x10 -> word 4, three consecutive grants.
    for (int c = 0; c < 4; c++) begin
      i_req  = (c < 3);
      i_addr = (c < 3) ? 32'h10 : 32'd0;
      mid_cycle();
      if (c < 3) begin
        check("f1 i_gnt",     {31'd0, i_gnt},   32'd1);
        check("f1 d_gnt",     {31'd0, d_gnt},   32'd0);
        check("f1 sram_addr", {22'd0, sram_addr}, 32'd4);
        check("f1 sram_we",   {31'd0, sram_we}, 32'd0);
      end
      check("f1 i_rvalid", {31'd0, i_rvalid}, (c > 0) ? 32'd1 : 32'd0);
      if (c > 0) check("f1 i_rdata", i_rdata, 32'hA000_0004);
      next_cycle();
    end
    mid_cycle();
    check("f1 i_rvalid end", {31'd0, i_rvalid}, 32'd0);
    check("f1 i_rdata end",  i_rdata, 32'd0);
    next_cycle();

    // 2/5: store 0xDEADBEEF to 0x8, then load 0x8 the following cycle.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h8; d_wdata = 32'hDEAD_BEEF;
    mid_cycle();
    check("st d_gnt",      {31'd0, d_gnt},   32'd1);
    check("st sram_we",    {31'd0, sram_we}, 32'd1);
    check("st sram_addr",  {22'd0, sram_addr}, 32'd2);
    check("st sram_wdata", sram_wdata, 32'hDEAD_BEEF);
    next_cycle();
    d_we = 1'b0;
    mid_cycle();
    check("ld d_gnt",    {31'd0, d_gnt},    32'd1);
    check("ld sram_we",  {31'd0, sram_we},  32'd0);
    check("st d_rvalid", {31'd0, d_rvalid}, 32'd0);
    next_cycle();
    idle_inputs();
    mid_cycle();
    check("ld d_rvalid",   {31'd0, d_rvalid}, 32'd1);
    check("ld d_rdata",    d_rdata, 32'hDEAD_BEEF);
    check("ld i_rvalid",   {31'd0, i_rvalid}, 32'd0);
    check("idle sram_addr", {22'd0, sram_addr}, 32'd0);
    check("idle sram_wdata", sram_wdata, 32'd0);
    next_cycle();

    // 5: lone store -> no read return, write strobe only on the grant cycle.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'hC; d_wdata = 32'h1234_5678;
    mid_cycle();
    check("st5 sram_we", {31'd0, sram_we}, 32'd1);
    next_cycle();
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      mid_cycle();
      check("st5 d_rvalid", {31'd0, d_rvalid}, 32'd0);
      check("st5 sram_we",  {31'd0, sram_we},  32'd0);
      next_cycle();
    end

    // 3/6: both ports busy for 10 cycles from a clean reset.
    pulse_reset();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(2'b01); exp_q.push_back(2'b01);
      exp_q.push_back(2'b01); exp_q.push_back(2'b01);
      exp_q.push_back(2'b10);
    end
    prev = 2'b00;
    run_grants("both", 10, 1'b1, 1'b1, prev);
    idle_inputs();
`ifdef MEM_ARB_STATS_EN
    check("stat_d_gnt",   dut.stat_d_gnt,   32'd8);
    check("stat_i_gnt",   dut.stat_i_gnt,   32'd2);
    check("stat_i_stall", dut.stat_i_stall, 32'd8);
`endif
    mid_cycle();
    check("both last i_rvalid", {31'd0, i_rvalid}, 32'd1);
    check("both last i_rdata",  i_rdata, 32'hA000_0008);
    next_cycle();

    // Data alone does not build a streak; fetch joining later waits 4 grants.
    for (int k = 0; k < 6; k++) exp_q.push_back(2'b01);
    prev = 2'b00;
    run_grants("d_only", 6, 1'b0, 1'b1, prev);
    exp_q.push_back(2'b01); exp_q.push_back(2'b01);
    exp_q.push_back(2'b01); exp_q.push_back(2'b01);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    run_grants("join", 6, 1'b1, 1'b1, prev);
    idle_inputs();
    next_cycle();

    // 4: load granted, reset asserted the next cycle, in-flight read dropped.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    mid_cycle();
    check("rl d_gnt", {31'd0, d_gnt}, 32'd1);
    next_cycle();
    rst = 1'b0;
    #1;
    check("rl d_rvalid", {31'd0, d_rvalid}, 32'd0);
    check("rl d_rdata",  d_rdata, 32'd0);
    check("rl d_gnt0",   {31'd0, d_gnt},   32'd0);
    check("rl sram_en",  {31'd0, sram_en}, 32'd0);
    next_cycle();
    idle_inputs();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      mid_cycle();
      check("rl post rvalid", {30'd0, i_rvalid, d_rvalid}, 32'd0);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the directed sequence is short; anything longer is a hang.
  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
